// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// State encoding and counter sizing helper.
package seq_divider_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Bits needed to hold the values 0..w
    function automatic int cnt_w(input int w);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < (w + 1)) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_divider_addsub.sv
// Generic adder/subtractor core; sub=1 yields a - b.
// Carry and signed-overflow flags are provided alongside the result.
module addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   full;

    assign bx   = b ^ {WIDTH{sub}};
    assign full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];
    assign ovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero flagged via div_zero.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last;
    logic             unused_cout;
    logic             unused_ovf;

    addsub #(
        .WIDTH(WIDTH + 1)
    ) u_trial (
        .a   ({rem_reg, q_reg[WIDTH-1]}),
        .b   ({1'b0, dvs_reg}),
        .sub (1'b1),
        .sum (trial),
        .cout(unused_cout),
        .ovf (unused_ovf)
    );

    // Negative trial restores the shifted partial remainder
    assign rem_nxt = trial[WIDTH] ? {rem_reg[WIDTH-2:0], q_reg[WIDTH-1]}
                                  : trial[WIDTH-1:0];
    assign q_nxt   = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
    assign last    = (count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg   <= '0;
            q_reg     <= '0;
            dvs_reg   <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvs_reg  <= divisor;
                        div_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end else begin
                            rem_reg <= '0;
                            q_reg   <= dividend;
                            count   <= CW'(WIDTH);
                        end
                    end
                end
                S_RUN: begin
                    rem_reg <= rem_nxt;
                    q_reg   <= q_nxt;
                    count   <= count - CW'(1);
                    if (last) begin
                        quotient  <= q_nxt;
                        remainder <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: reference results come from plain
// integer division, a monitor pops and compares on every done pulse.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q  = W'((1 << W) - 1);
            e.r  = W'(a);
            e.dz = 1'b1;
        end else begin
            e.q  = W'(a / b);
            e.r  = W'(a % b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got q=%0h r=%0h with nothing pending",
                         quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_zero", div_zero, e.dz);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit poke);
        exp_t e;
        int   n;
        int   bc;
        e = model(a, b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        sb.push_back(e);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        n  = 0;
        bc = 0;
        while (n < 20) begin
            @(negedge clk);
            if (done) break;
            if (busy) bc++;
            if (n == 0) begin
                chk("dz_cleared", div_zero, 0);
                chk("hold_q", quotient, last_q);
                chk("hold_r", remainder, last_r);
            end
            if (poke && n == 1) begin
                start    = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end else begin
                start = 1'b0;
            end
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done in %0d cycles for %0h/%0h",
                     n, a, b);
        end else begin
            chk("latency", n, (b == 0) ? 0 : W);
            chk("busy_cycles", bc, (b == 0) ? 0 : W);
        end
        start  = 1'b0;
        last_q = e.q;
        last_r = e.r;
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   gap;
        int   dn;

        #12;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        op(4'b1111, 4'b0011, 0);
        op(4'b1011, 4'b0011, 1);
        op(4'b0011, 4'b1111, 0);
        op(4'b0111, 4'b0000, 0);
        op(4'b1111, 4'b0001, 0);

        // Abort mid-run with an off-edge reset pulse
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'b1000;
        divisor  = 4'b0111;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dz", div_zero, 0);
        #2;
        rst_n  = 1'b1;
        last_q = '0;
        last_r = '0;
        repeat (8) @(negedge clk);
        op(4'b1000, 4'b0111, 0);

        // start held high across three back-to-back operations
        @(negedge clk);
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom_range(15, 1));
        e = model(dividend, divisor);
        sb.push_back(e);
        gap = 0;
        dn  = 0;
        for (int c = 0; c < 60 && dn < 3; c++) begin
            @(negedge clk);
            gap++;
            if (done) begin
                if (dn > 0) chk("held_gap", gap, W + 2);
                gap = 0;
                dn++;
                if (dn < 3) begin
                    dividend = W'($urandom);
                    divisor  = W'($urandom_range(15, 1));
                    e = model(dividend, divisor);
                    sb.push_back(e);
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (dn < 3) begin
            tests++;
            fails++;
            $display("FAIL held_timeout: got %0d dones expected 3", dn);
        end
        last_q = e.q;
        last_r = e.r;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = ($urandom_range(7, 0) == 0) ? '0 : W'($urandom);
            op(ra, rb, $urandom_range(1, 0) == 1);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op(W'(a), W'(b), 0);
            end
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
